requant_pack: RTL and testbench

REQUANT_PACK -- requirements
Module: requant_pack

---
 rtl/requant_pack.sv | 202 ++++++++++++++++++++
 tb/tb_requant_pack.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/requant_pack.sv
// requant_pack
//   Requantises signed 32-bit MAC accumulators to int8 and packs up to four
//   results per 32-bit output word.
//
//   Pipeline (every stage moves only on adv = !out_valid || out_ready):
//     S1 : x = sat32(in_acc + in_bias)                               -> x_q
//     S2 : y = saturating rounding doubling high multiply(x, mult)  -> y_q
//     S3 : q = clamp(round_shift(y, shift) + zp, min, max)  (comb from y_q)
//     packer : q goes into byte[lane]; on lane 3 or last, the word moves to
//              the output register.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_en                     config load strobe (ignored while busy)
//   cfg_mult/shift/zp/min/max  Q31 multiplier, right shift, zero point, clamps
//   in_valid/in_ready          input handshake
//   in_acc/in_bias/in_last     accumulator, bias, flush after this item
//   out_valid/out_ready        output handshake
//   out_data/out_cnt           packed int8 bytes (byte 0 first), byte count
//   busy                       any stage, partial word or output register full
module requant_pack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_en,
    input  logic [31:0] cfg_mult,
    input  logic [4:0]  cfg_shift,
    input  logic [8:0]  cfg_zp,
    input  logic [7:0]  cfg_min,
    input  logic [7:0]  cfg_max,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_acc,
    input  logic [31:0] in_bias,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_cnt,
    output logic        busy
);

    // configuration
    logic [31:0] mult_q;
    logic [4:0]  shift_q;
    logic [8:0]  zp_q;
    logic [7:0]  min_q;
    logic [7:0]  max_q;

    // pipeline
    logic        v1_q, last1_q;
    logic [31:0] x_q;
    logic        v2_q, last2_q;
    logic [31:0] y_q;

    // packer and output register
    logic [1:0]  lane_q;
    logic [23:0] pack_q;
    logic        out_valid_q;
    logic [31:0] out_data_q;
    logic [2:0]  out_cnt_q;

    logic        adv;
    logic [31:0] x_d;
    logic [31:0] y_d;
    logic [7:0]  q_d;
    logic [31:0] word_d;
    logic        flush;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_cnt   = out_cnt_q;
    assign busy      = v1_q | v2_q | (lane_q != 2'd0) | out_valid_q;

    // ---------------- S1: saturating add ----------------
    logic signed [32:0] s1_sum;
    assign s1_sum = $signed({in_acc[31], in_acc}) + $signed({in_bias[31], in_bias});

    always_comb begin
        if (!s1_sum[32] && s1_sum[31])
            x_d = 32'h7FFF_FFFF;
        else if (s1_sum[32] && !s1_sum[31])
            x_d = 32'h8000_0000;
        else
            x_d = s1_sum[31:0];
    end

    // ---------------- S2: SRDHM ----------------
    logic signed [63:0] s2_prod;
    logic signed [63:0] s2_nudge;
    logic signed [63:0] s2_rnd;
    logic signed [63:0] s2_adj;

    assign s2_prod  = $signed({{32{x_q[31]}}, x_q}) * $signed({{32{mult_q[31]}}, mult_q});
    // nudge = +2^30 for a non-negative product, 1 - 2^30 otherwise
    assign s2_nudge = s2_prod[63] ? 64'shFFFF_FFFF_C000_0001 : 64'sh0000_0000_4000_0000;
    assign s2_rnd   = s2_prod + s2_nudge;
    // bias negative values by 2^31-1 so the arithmetic shift truncates toward zero
    assign s2_adj   = s2_rnd[63] ? s2_rnd + 64'sh0000_0000_7FFF_FFFF : s2_rnd;

    // only min*min overflows the 32-bit result; every other product fits
    assign y_d = (x_q == 32'h8000_0000 && mult_q == 32'h8000_0000) ? 32'h7FFF_FFFF
                                                                    : s2_adj[62:31];

    // ---------------- S3: rounding shift, zero point, clamp ----------------
    logic [31:0]        s3_mask;
    logic [31:0]        s3_rem;
    logic [31:0]        s3_thr;
    logic signed [31:0] s3_shr;
    logic signed [32:0] s3_r;
    logic signed [32:0] s3_z;
    logic signed [32:0] s3_min;
    logic signed [32:0] s3_max;

    assign s3_mask = (32'd1 << shift_q) - 32'd1;
    assign s3_rem  = y_q & s3_mask;
    // threshold is one higher for negatives, so ties round away from zero
    assign s3_thr  = (s3_mask >> 1) + {31'd0, y_q[31]};
    assign s3_shr  = $signed(y_q) >>> shift_q;
    assign s3_r    = $signed({s3_shr[31], s3_shr}) + $signed({32'd0, (s3_rem > s3_thr)});
    assign s3_z    = s3_r + $signed({{24{zp_q[8]}}, zp_q});
    assign s3_min  = $signed({{25{min_q[7]}}, min_q});
    assign s3_max  = $signed({{25{max_q[7]}}, max_q});

    always_comb begin
        if (s3_min > s3_max)
            q_d = max_q;                // inverted bounds: max wins
        else if (s3_z < s3_min)
            q_d = min_q;
        else if (s3_z > s3_max)
            q_d = max_q;
        else
            q_d = s3_z[7:0];
    end

    // ---------------- packer ----------------
    // bytes above the current lane are always zero in pack_q
    always_comb begin
        word_d = {8'd0, pack_q};
        case (lane_q)
            2'd0: word_d[7:0]   = q_d;
            2'd1: word_d[15:8]  = q_d;
            2'd2: word_d[23:16] = q_d;
            2'd3: word_d[31:24] = q_d;
        endcase
    end

    assign flush = v2_q && ((lane_q == 2'd3) || last2_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_q      <= 32'd0;
            shift_q     <= 5'd0;
            zp_q        <= 9'd0;
            min_q       <= 8'h80;
            max_q       <= 8'h7F;
            v1_q        <= 1'b0;
            last1_q     <= 1'b0;
            x_q         <= 32'd0;
            v2_q        <= 1'b0;
            last2_q     <= 1'b0;
            y_q         <= 32'd0;
            lane_q      <= 2'd0;
            pack_q      <= 24'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            out_cnt_q   <= 3'd0;
        end else begin
            if (cfg_en && !busy) begin
                mult_q  <= cfg_mult;
                shift_q <= cfg_shift;
                zp_q    <= cfg_zp;
                min_q   <= cfg_min;
                max_q   <= cfg_max;
            end
            if (adv) begin
                v1_q        <= in_valid;
                x_q         <= x_d;
                last1_q     <= in_last;
                v2_q        <= v1_q;
                y_q         <= y_d;
                last2_q     <= last1_q;
                // loading and draining on the same edge keeps out_valid high
                out_valid_q <= flush;
                if (flush) begin
                    out_data_q <= word_d;
                    out_cnt_q  <= {1'b0, lane_q} + 3'd1;
                    lane_q     <= 2'd0;
                    pack_q     <= 24'd0;
                end else if (v2_q) begin
                    lane_q <= lane_q + 2'd1;
                    pack_q <= word_d[23:0];
                end
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{s2_adj[63], s2_adj[30:0]};

endmodule

// File: tb/tb_requant_pack.sv
module tb_requant_pack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_en = 1'b0;
    logic [31:0] cfg_mult = 32'd0;
    logic [4:0]  cfg_shift = 5'd0;
    logic [8:0]  cfg_zp = 9'd0;
    logic [7:0]  cfg_min = 8'h80;
    logic [7:0]  cfg_max = 8'h7F;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_acc = 32'd0;
    logic [31:0] in_bias = 32'd0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [2:0]  out_cnt;
    logic        busy;

    always #5 clk = ~clk;

    requant_pack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_en    (cfg_en),
        .cfg_mult  (cfg_mult),
        .cfg_shift (cfg_shift),
        .cfg_zp    (cfg_zp),
        .cfg_min   (cfg_min),
        .cfg_max   (cfg_max),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_acc    (in_acc),
        .in_bias   (in_bias),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt),
        .busy      (busy)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   stall_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // monitor: pops one expected word per output transfer
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got %h cnt %0d, expected no word", out_data, out_cnt);
            end else begin
                mon_e = exp_q.pop_front();
                check("word_data", out_data, mon_e.data);
                check("word_cnt", 32'(out_cnt), 32'(mon_e.cnt));
            end
        end
        if (rst_n && out_valid && !out_ready)
            check("in_ready_while_stalled", 32'(in_ready), 32'd0);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [31:0] m, input logic [4:0] s, input logic [8:0] zp,
                          input logic [7:0] mn, input logic [7:0] mx);
        cfg_mult  = m;
        cfg_shift = s;
        cfg_zp    = zp;
        cfg_min   = mn;
        cfg_max   = mx;
        cfg_en    = 1'b1;
        tick();
        cfg_en    = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input logic [2:0] c);
        exp_q.push_back({d, c});
    endtask

    task automatic send(input logic [31:0] acc, input logic [31:0] bias, input logic last);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        in_acc   = acc;
        in_bias  = bias;
        in_last  = last;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        stall_cycles += n - 1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("send_accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle;
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < 500) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !busy;
            n++;
        end
        tick();
        check("drained_idle", 32'(done), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_cnt", 32'(out_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 32'd1);
        tick();

        // half multiplier, four items fill one word
        do_cfg(32'h4000_0000, 5'd0, 9'd0, 8'h80, 8'h7F);
        push(32'h3232_3232, 3'd4);
        for (int i = 0; i < 4; i++) send(32'd100, 32'd0, 1'b0);
        wait_idle();

        // negative value with shift 1 and early flush
        do_cfg(32'h7FFF_FFFF, 5'd1, 9'd0, 8'h80, 8'h7F);
        push(32'h0000_00FE, 3'd1);
        send(32'hFFFF_FFFD, 32'd0, 1'b1);
        wait_idle();

        // zero point, upper clamp, and S1 bias saturation
        do_cfg(32'h7FFF_FFFF, 5'd0, 9'd10, 8'h80, 8'h64);
        push(32'h0000_6464, 3'd2);
        send(32'd1000, 32'd0, 1'b0);
        send(32'h7FFF_FFFF, 32'd1, 1'b1);
        wait_idle();

        // SRDHM min*min saturation
        do_cfg(32'h8000_0000, 5'd0, 9'd0, 8'h80, 8'h7F);
        push(32'h0000_007F, 3'd1);
        send(32'h8000_0000, 32'd0, 1'b1);
        wait_idle();

        // rounding shift by 2: 6->2, 5->1, -6->-2, -7->-2
        do_cfg(32'h7FFF_FFFF, 5'd2, 9'd0, 8'h80, 8'h7F);
        push(32'hFEFE_0102, 3'd4);
        send(32'd6, 32'd0, 1'b0);
        send(32'd5, 32'd0, 1'b0);
        send(32'hFFFF_FFFA, 32'd0, 1'b0);
        send(32'hFFFF_FFF9, 32'd0, 1'b1);
        wait_idle();

        // negative zero point and lower clamp
        do_cfg(32'h7FFF_FFFF, 5'd0, 9'h1FB, 8'h80, 8'h7F);
        push(32'h0000_80FE, 3'd2);
        send(32'd3, 32'd0, 1'b0);
        send(32'hFFFF_FF38, 32'd0, 1'b1);
        wait_idle();

        // inverted bounds (min 50 > max 20): always max
        do_cfg(32'h7FFF_FFFF, 5'd0, 9'd0, 8'd50, 8'd20);
        push(32'h0000_1414, 3'd2);
        send(32'd30, 32'd0, 1'b0);
        send(32'hFFFF_FF9C, 32'd0, 1'b1);
        wait_idle();

        // two items with last, then a full word
        do_cfg(32'h4000_0000, 5'd0, 9'd0, 8'h80, 8'h7F);
        push(32'h0000_F60A, 3'd2);
        send(32'd20, 32'd0, 1'b0);
        send(32'hFFFF_FFEC, 32'd0, 1'b1);
        push(32'h0403_0201, 3'd4);
        send(32'd2, 32'd0, 1'b0);
        send(32'd4, 32'd0, 1'b0);
        send(32'd6, 32'd0, 1'b0);
        send(32'd8, 32'd0, 1'b0);
        wait_idle();

        // config strobe while busy is ignored
        do_cfg(32'h7FFF_FFFF, 5'd0, 9'd0, 8'h80, 8'h7F);
        push(32'h0000_0709, 3'd2);
        send(32'd9, 32'd0, 1'b0);
        do_cfg(32'h4000_0000, 5'd0, 9'd0, 8'h80, 8'h7F);
        send(32'd7, 32'd0, 1'b1);
        wait_idle();

        // back-to-back stream with out_ready high: no bubbles
        stall_cycles = 0;
        push(32'h0403_0201, 3'd4);
        push(32'h0807_0605, 3'd4);
        for (int i = 1; i <= 8; i++) send(32'(i), 32'd0, 1'b0);
        check("no_bubble_stalls", 32'(stall_cycles), 32'd0);
        wait_idle();

        // 12-item stream with 10 cycles of output back-pressure
        stall_cycles = 0;
        push(32'h0403_0201, 3'd4);
        push(32'h0807_0605, 3'd4);
        push(32'h0C0B_0A09, 3'd4);
        fork
            begin
                for (int i = 1; i <= 12; i++) send(32'(i), 32'd0, 1'b0);
            end
            begin
                out_ready = 1'b0;
                repeat (10) tick();
                out_ready = 1'b1;
            end
        join
        check("stall_observed", 32'(stall_cycles > 0), 32'd1);
        wait_idle();

        // reset mid-stream drops the partial word and restores config
        send(32'd1, 32'd0, 1'b0);
        send(32'd2, 32'd0, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_out_cnt", 32'(out_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_midrst", 32'(in_ready), 32'd1);
        tick();
        push(32'h0000_0000, 3'd1);          // reset multiplier is 0
        send(32'd77, 32'd0, 1'b1);
        wait_idle();
        do_cfg(32'h7FFF_FFFF, 5'd0, 9'd0, 8'h80, 8'h7F);
        push(32'h0000_0005, 3'd1);
        send(32'd5, 32'd0, 1'b1);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
